// File: rtl/sort_pkg.sv
// Shared types and sizes for the selection-sorter stream controller.
package sort_pkg;

    localparam int SORT_DW = 8;
    localparam int SORT_AW = 3;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        SORT,
        RD_ADDR,
        RD_DATA,
        EMIT
    } sctl_state_t;

endpackage

// File: rtl/sort_stream_ctrl_if.sv
// Input and output stream bundle of the sorter controller.
// slave: the controller side; master: the producer/consumer environment side.
interface sort_stream_ctrl_if
    import sort_pkg::*;
#(
    parameter int DW = SORT_DW
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sort_order_check.sv
// Drain-side order checker: sticky flag when a word is smaller than its predecessor.
// Only built when SORT_CHECK_EN is defined.
`ifdef SORT_CHECK_EN
module sort_order_check
    import sort_pkg::*;
#(
    parameter int DW = SORT_DW
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          xfer,
    input  logic          first,
    input  logic [DW-1:0] data,
    output logic          err
);
    logic [DW-1:0] prev_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q <= '0;
            err    <= 1'b0;
        end else if (xfer) begin
            prev_q <= data;
            // The first word of a frame has no predecessor in the same frame.
            if (!first && (data < prev_q))
                err <= 1'b1;
        end
    end
endmodule
`endif

// File: rtl/sort_stream_ctrl.sv
// Stream front/back end for the 8-entry selection sorter: load a frame, start the
// sorter, drain sorted words with last. SORT_CHECK_EN adds the sticky order checker.
module sort_stream_ctrl
    import sort_pkg::*;
#(
    parameter int DW = SORT_DW,
    parameter int AW = SORT_AW
) (
    input  logic                clk,
    input  logic                nrst,
    sort_stream_ctrl_if.slave   st,
    output logic [AW-1:0]       srt_addr,
    output logic [DW-1:0]       srt_datain,
    output logic                srt_wr,
    output logic                srt_start,
    input  logic                srt_ready,
    input  logic [DW-1:0]       srt_dataout,
    output logic                sort_err
);
    localparam logic [AW-1:0] K_LAST = {AW{1'b1}};

    sctl_state_t   state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          s_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= LOAD;
            k_q       <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        s_ready    = 1'b0;
        srt_wr     = 1'b0;
        srt_datain = '0;
        srt_start  = 1'b0;

        case (state_q)
            LOAD: begin
                s_ready = 1'b1;
                if (st.s_valid) begin
                    srt_wr     = 1'b1;
                    srt_datain = st.s_data;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = START;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            START: begin
                // Pulse start only into an idle sorter; otherwise keep waiting.
                if (srt_ready) begin
                    srt_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT:    state_d = SORT;
            SORT:    if (srt_ready) state_d = RD_ADDR;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                // Sorter read data is registered: it reflects the address from RD_ADDR.
                m_data_d  = srt_dataout;
                m_valid_d = 1'b1;
                m_last_d  = (k_q == K_LAST);
                state_d   = EMIT;
            end
            EMIT: begin
                if (st.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = LOAD;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = RD_ADDR;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign srt_addr   = k_q;
    assign st.s_ready = s_ready;
    assign st.m_valid = m_valid_q;
    assign st.m_last  = m_last_q;
    assign st.m_data  = m_data_q;

`ifdef SORT_CHECK_EN
    sort_order_check #(.DW(DW)) u_order_check (
        .clk   (clk),
        .nrst  (nrst),
        .xfer  (m_valid_q && st.m_ready),
        .first (k_q == '0),
        .data  (m_data_q),
        .err   (sort_err)
    );
`else
    assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Self-checking bench for sort_stream_ctrl with a behavioural 8-entry sorter model.
// Expected output of each frame is the input frame sorted ascending (queue sort).
module tb_sort_stream_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = 8;

    typedef logic [DW-1:0] word_t;
    typedef word_t frame_t [N];

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    sort_stream_ctrl_if #(.DW(DW)) st ();
    logic [AW-1:0] srt_addr;
    word_t         srt_datain, srt_dataout;
    logic          srt_wr, srt_start, srt_ready, sort_err;

    sort_stream_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .st          (st),
        .srt_addr    (srt_addr),
        .srt_datain  (srt_datain),
        .srt_wr      (srt_wr),
        .srt_start   (srt_start),
        .srt_ready   (srt_ready),
        .srt_dataout (srt_dataout),
        .sort_err    (sort_err)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    bad_sorter = 1'b0;
    word_t exp_q[$];
    word_t got_d[$];
    bit    got_l[$];
    int    got_c[$];
    int    wr_addr[$];
    word_t wr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Sorter model: external RAM port, busy for a random time after start, then
    // places every word at its rank (ties broken by original position).
    word_t smem [N];
    int    busy_cnt;

    function automatic int rank_of(int i);
        int r = 0;
        for (int j = 0; j < N; j++)
            if (smem[j] < smem[i] || (smem[j] == smem[i] && j < i)) r++;
        return r;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            srt_ready   <= 1'b1;
            busy_cnt    <= 0;
            srt_dataout <= '0;
        end else begin
            srt_dataout <= smem[srt_addr];
            if (srt_wr) smem[srt_addr] <= srt_datain;
            if (srt_start && srt_ready) begin
                srt_ready <= 1'b0;
                busy_cnt  <= 4 + int'($urandom_range(0, 8));
            end else if (!srt_ready) begin
                if (busy_cnt == 0) begin
                    for (int i = 0; i < N; i++) smem[rank_of(i)] <= smem[i];
                    if (bad_sorter) begin
                        smem[0] <= 8'd4;
                        smem[1] <= 8'd2;
                    end
                    srt_ready <= 1'b1;
                end else begin
                    busy_cnt <= busy_cnt - 1;
                end
            end
        end
    end

    // Bus monitor: logs sorter writes; start must only hit an idle sorter.
    always @(negedge clk) begin
        #2;
        if (nrst) begin
            if (srt_wr) begin
                wr_addr.push_back(int'(srt_addr));
                wr_data.push_back(srt_datain);
            end
            if (srt_start) begin
                n_tests++;
                if (!srt_ready) begin
                    n_fail++;
                    $display("FAIL start_when_busy srt_ready=%0b want 1 at cycle %0d", srt_ready, cyc);
                end
            end
        end
    end

    task automatic add_expected(input frame_t d);
        word_t q[$];
        foreach (d[i]) q.push_back(d[i]);
        q.sort();
        foreach (q[i]) exp_q.push_back(q[i]);
    endtask

    task automatic clear_logs();
        exp_q = {}; got_d = {}; got_l = {}; got_c = {}; wr_addr = {}; wr_data = {};
    endtask

    // mode 0: s_valid always high, 1: toggles 1/0, 2: random
    task automatic send_frame(input frame_t d, input int mode, output int first_cyc);
        int i = 0;
        int n = 0;
        first_cyc = -1;
        while (i < N && n < 3000) begin
            @(negedge clk);
            n++;
            st.s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 1) : ($urandom_range(0, 2) != 0);
            st.s_data  = d[i];
            #1;
            if (st.s_valid && st.s_ready) begin
                if (i == 0) first_cyc = cyc;
                i++;
            end
        end
        if (i < N) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout sent=%0d want=%0d", i, N);
        end
    endtask

    task automatic end_send();
        @(negedge clk);
        st.s_valid = 1'b0;
    endtask

    task automatic recv_words(input int cnt, input bit rnd);
        int n = 0;
        int target = got_d.size() + cnt;
        while (got_d.size() < target && n < 3000) begin
            @(negedge clk);
            n++;
            st.m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (st.m_valid && st.m_ready) begin
                got_d.push_back(st.m_data);
                got_l.push_back(st.m_last);
                got_c.push_back(cyc);
            end
        end
        if (got_d.size() < target) begin
            n_tests++; n_fail++;
            $display("FAIL recv_timeout got=%0d want=%0d", got_d.size(), target);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        st.s_valid = 1'b0; st.s_data = '0; st.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({st.s_ready, st.m_valid, st.m_last, srt_wr, srt_start, sort_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=100000",
                     {st.s_ready, st.m_valid, st.m_last, srt_wr, srt_start, sort_err});
        end
        n_tests++;
        if (st.m_data !== '0 || srt_addr !== '0 || srt_datain !== '0) begin
            n_fail++;
            $display("FAIL reset_buses got m_data=%0d addr=%0d datain=%0d want 0/0/0",
                     st.m_data, srt_addr, srt_datain);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_basic();
        frame_t f = '{8'd5, 8'd3, 8'd7, 8'd0, 8'd255, 8'd1, 8'd1, 8'd2};
        int fc;
        clear_logs();
        add_expected(f);
        fork
            begin send_frame(f, 0, fc); end_send(); end
            recv_words(N, 1'b0);
        join
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == N - 1)) begin
                n_fail++;
                $display("FAIL basic_word%0d got data=%0d last=%0b want data=%0d last=%0b",
                         i, got_d[i], got_l[i], exp_q[i], (i == N - 1));
            end
        end
        for (int i = 1; i < N; i++) begin
            n_tests++;
            if (got_c[i] - got_c[i-1] !== 3) begin
                n_fail++;
                $display("FAIL basic_drain_rate%0d got=%0d cycles want=3", i, got_c[i] - got_c[i-1]);
            end
        end
    endtask

    task automatic test_gappy_load();
        frame_t f = '{8'd5, 8'd3, 8'd7, 8'd0, 8'd255, 8'd1, 8'd1, 8'd2};
        int fc;
        clear_logs();
        add_expected(f);
        fork
            begin send_frame(f, 1, fc); end_send(); end
            recv_words(N, 1'b0);
        join
        n_tests++;
        if (wr_addr.size() !== N) begin
            n_fail++;
            $display("FAIL gappy_wr_count got=%0d want=%0d", wr_addr.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (wr_addr[i] !== i || wr_data[i] !== f[i] || got_d[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gappy_%0d got addr=%0d wdata=%0d out=%0d want addr=%0d wdata=%0d out=%0d",
                         i, wr_addr[i], wr_data[i], got_d[i], i, f[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        frame_t f = '{8'd5, 8'd3, 8'd7, 8'd0, 8'd255, 8'd1, 8'd1, 8'd2};
        int fc;
        int k = 0;
        clear_logs();
        add_expected(f);
        fork
            begin send_frame(f, 0, fc); end_send(); end
            begin
                recv_words(3, 1'b0);
                do begin
                    @(negedge clk);
                    st.m_ready = 1'b0;
                    #1;
                    k++;
                end while (!st.m_valid && k < 50);
                repeat (10) begin
                    n_tests++;
                    if (st.m_valid !== 1'b1 || st.m_data !== exp_q[3] || st.m_last !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold got valid=%0b data=%0d last=%0b want 1/%0d/0",
                                 st.m_valid, st.m_data, st.m_last, exp_q[3]);
                    end
                    @(negedge clk);
                    #1;
                end
                recv_words(5, 1'b0);
            end
        join
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == N - 1)) begin
                n_fail++;
                $display("FAIL stall_word%0d got data=%0d last=%0b want data=%0d last=%0b",
                         i, got_d[i], got_l[i], exp_q[i], (i == N - 1));
            end
        end
    endtask

    task automatic test_reset_mid_sort();
        frame_t fa = '{8'd40, 8'd30, 8'd20, 8'd10, 8'd70, 8'd60, 8'd50, 8'd0};
        frame_t fb = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        int fc;
        int k = 0;
        clear_logs();
        send_frame(fa, 0, fc);
        end_send();
        while (srt_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_tests++;
        if ({st.s_ready, st.m_valid, st.m_last, srt_wr, srt_start, sort_err} !== 6'b100000 ||
            st.m_data !== '0 || srt_addr !== '0 || srt_datain !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got flags=%b data=%0d addr=%0d want flags=100000 data=0 addr=0",
                     {st.s_ready, st.m_valid, st.m_last, srt_wr, srt_start, sort_err}, st.m_data, srt_addr);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        clear_logs();
        add_expected(fb);
        fork
            begin send_frame(fb, 0, fc); end_send(); end
            recv_words(N, 1'b0);
        join
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == N - 1)) begin
                n_fail++;
                $display("FAIL midreset_word%0d got data=%0d last=%0b want data=%0d last=%0b",
                         i, got_d[i], got_l[i], exp_q[i], (i == N - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f1 = '{default: 8'd9};
        frame_t f2 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        int fc1, fc2;
        clear_logs();
        add_expected(f1);
        add_expected(f2);
        fork
            begin send_frame(f1, 0, fc1); send_frame(f2, 0, fc2); end_send(); end
            begin recv_words(N, 1'b0); recv_words(N, 1'b0); end
        join
        for (int i = 0; i < 2 * N; i++) begin
            n_tests++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i % N == N - 1)) begin
                n_fail++;
                $display("FAIL b2b_word%0d got data=%0d last=%0b want data=%0d last=%0b",
                         i, got_d[i], got_l[i], exp_q[i], (i % N == N - 1));
            end
        end
        n_tests++;
        if (fc2 !== got_c[N-1] + 1) begin
            n_fail++;
            $display("FAIL b2b_gap got first_load=%0d want=%0d", fc2, got_c[N-1] + 1);
        end
    endtask

    task automatic test_random();
        frame_t f;
        int fc;
        for (int r = 0; r < 4; r++) begin
            foreach (f[i]) f[i] = word_t'($urandom_range(0, 255));
            clear_logs();
            add_expected(f);
            fork
                begin send_frame(f, 2, fc); end_send(); end
                recv_words(N, 1'b1);
            join
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if (got_d[i] !== exp_q[i] || got_l[i] !== (i == N - 1)) begin
                    n_fail++;
                    $display("FAIL random%0d_word%0d got data=%0d last=%0b want data=%0d last=%0b",
                             r, i, got_d[i], got_l[i], exp_q[i], (i == N - 1));
                end
            end
        end
    endtask

    task automatic test_order_check();
`ifdef SORT_CHECK_EN
        frame_t f = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        int fc;
        n_tests++;
        if (sort_err !== 1'b0) begin
            n_fail++;
            $display("FAIL check_clean got sort_err=%0b want 0", sort_err);
        end
        clear_logs();
        bad_sorter = 1'b1;
        fork
            begin send_frame(f, 0, fc); end_send(); end
            recv_words(N, 1'b0);
        join
        bad_sorter = 1'b0;
        n_tests++;
        if (sort_err !== 1'b1) begin
            n_fail++;
            $display("FAIL check_flag got sort_err=%0b want 1", sort_err);
        end
        clear_logs();
        fork
            begin send_frame(f, 0, fc); end_send(); end
            recv_words(N, 1'b0);
        join
        n_tests++;
        if (sort_err !== 1'b1) begin
            n_fail++;
            $display("FAIL check_sticky got sort_err=%0b want 1", sort_err);
        end
`else
        n_tests++;
        if (sort_err !== 1'b0) begin
            n_fail++;
            $display("FAIL check_tied got sort_err=%0b want 0", sort_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gappy_load();
        test_stall();
        test_reset_mid_sort();
        test_back_to_back();
        test_random();
        test_order_check();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
